// File: rtl/multi_sel_block_if.sv
// Bundles the handshake and data signals of multi_sel_block.
// The slave modport is the block's view; the master modport is the upstream/downstream view.
interface multi_sel_block_if #(
  parameter int WEIGHT_N   = 5,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1
);
  localparam int BEATS  = (WEIGHT_N + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                           done_in;
  logic                           stall_in;
  logic [DATA_WIDTH*WEIGHT_N-1:0] data_in;
  logic [DATA_WIDTH*LANES-1:0]    data_out;
  logic [LANES-1:0]               lane_valid;
  logic [BEAT_W-1:0]              beat_idx;
  logic                           first_out;
  logic                           last_out;
  logic                           done_out;
  logic                           freeze_r;
  logic                           busy;

  modport master (
    output done_in, stall_in, data_in,
    input  data_out, lane_valid, beat_idx, first_out, last_out,
           done_out, freeze_r, busy
  );

  modport slave (
    input  done_in, stall_in, data_in,
    output data_out, lane_valid, beat_idx, first_out, last_out,
           done_out, freeze_r, busy
  );
endinterface

// File: rtl/multi_sel_block.sv
// Streams a packed vector of WEIGHT_N words out LANES words per beat.
// A start request walks beat_idx from 0 to BEATS-1, then emits a one-cycle
// done pulse. Requests arriving while busy are remembered in a one-deep
// pending flag so a second sequence can follow immediately.
module multi_sel_block #(
  parameter int WEIGHT_N   = 5,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1
) (
  input logic             clk,
  input logic             rst,
  multi_sel_block_if.slave bus
);
  localparam int BEATS  = (WEIGHT_N + LANES - 1) / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Word slots are padded to a power of two so any beat/lane index is in range.
  localparam int SLOT_W = (BEATS * LANES > 1) ? $clog2(BEATS * LANES) : 1;
  localparam int SLOTS  = 2 ** SLOT_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pending_q, pending_d;
  logic              done_q, done_d;
  logic              freeze_q, freeze_d;
  logic              busy_q, busy_d;

  logic [DATA_WIDTH-1:0] slot_word [SLOTS];
  logic                  slot_ok   [SLOTS];

  logic [DATA_WIDTH*LANES-1:0] data_c;
  logic [LANES-1:0]            valid_c;
  logic                        first_c;
  logic                        last_c;

  // Unpack data_in into slots; slots past the last real word read as invalid zeros.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < WEIGHT_N) begin : g_real
      assign slot_word[k] = bus.data_in[DATA_WIDTH*k +: DATA_WIDTH];
      assign slot_ok[k]   = 1'b1;
    end else begin : g_pad
      assign slot_word[k] = '0;
      assign slot_ok[k]   = 1'b0;
    end
  end

  // Sequencer: start, advance or hold the beat, finish, and chain a pending request.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pending_d = pending_q;
    done_d    = done_q;
    freeze_d  = freeze_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.done_in) begin
          state_d  = RUN;
          beat_d   = '0;
          freeze_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (bus.done_in) begin
          pending_d = 1'b1;
        end
        if (!bus.stall_in) begin
          if (beat_q == LAST_BEAT) begin
            state_d  = DONE;
            beat_d   = '0;
            done_d   = 1'b1;
            freeze_d = 1'b1;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        done_d = 1'b0;
        beat_d = '0;
        if (pending_q || bus.done_in) begin
          state_d   = RUN;
          pending_d = 1'b0;
          freeze_d  = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d  = IDLE;
          freeze_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        beat_d    = '0;
        pending_d = 1'b0;
        done_d    = 1'b0;
        freeze_d  = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset takes effect without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      freeze_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      freeze_q  <= freeze_d;
      busy_q    <= busy_d;
    end
  end

  // Lane selection for the current beat; everything is zero outside RUN.
  always_comb begin
    logic [SLOT_W-1:0] slot;
    slot    = '0;
    data_c  = '0;
    valid_c = '0;
    first_c = 1'b0;
    last_c  = 1'b0;
    if (state_q == RUN) begin
      first_c = (beat_q == '0);
      last_c  = (beat_q == LAST_BEAT);
      for (int i = 0; i < LANES; i++) begin
        slot = SLOT_W'(beat_q) * SLOT_W'(LANES) + SLOT_W'(i);
        if (slot_ok[slot]) begin
          data_c[DATA_WIDTH*i +: DATA_WIDTH] = slot_word[slot];
          valid_c[i]                         = 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = data_c;
  assign bus.lane_valid = valid_c;
  assign bus.first_out  = first_c;
  assign bus.last_out   = last_c;
  assign bus.beat_idx   = beat_q;
  assign bus.done_out   = done_q;
  assign bus.freeze_r   = freeze_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_multi_sel_block.sv
// Directed bench for multi_sel_block in three configurations:
// A = 5 words x 1 lane, B = 5 words x 2 lanes, C = 1 word x 1 lane.
module tb_multi_sel_block;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  multi_sel_block_if #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(1)) if_a ();
  multi_sel_block_if #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(2)) if_b ();
  multi_sel_block_if #(.WEIGHT_N(1), .DATA_WIDTH(16), .LANES(1)) if_c ();

  multi_sel_block #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  multi_sel_block #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  multi_sel_block #(.WEIGHT_N(1), .DATA_WIDTH(16), .LANES(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives the request/stall inputs, then advances to 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic done_a, input logic stall_a,
                               input logic done_b, input logic done_c);
    if_a.done_in  = done_a;
    if_a.stall_in = stall_a;
    if_b.done_in  = done_b;
    if_c.done_in  = done_c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expectA(input string tag, input logic [15:0] d, input logic v, input int beat,
                         input logic f, input logic l, input logic dn, input logic fr, input logic bs);
    checkOutput({tag, ".a.data"},  64'(if_a.data_out), 64'(d));
    checkOutput({tag, ".a.valid"}, 64'(if_a.lane_valid), 64'(v));
    checkOutput({tag, ".a.beat"},  64'(if_a.beat_idx), 64'(beat));
    checkOutput({tag, ".a.flags"},
                64'({if_a.first_out, if_a.last_out, if_a.done_out, if_a.freeze_r, if_a.busy}),
                64'({f, l, dn, fr, bs}));
  endtask

  task automatic expectB(input string tag, input logic [31:0] d, input logic [1:0] v, input int beat,
                         input logic f, input logic l, input logic dn, input logic fr, input logic bs);
    checkOutput({tag, ".b.data"},  64'(if_b.data_out), 64'(d));
    checkOutput({tag, ".b.valid"}, 64'(if_b.lane_valid), 64'(v));
    checkOutput({tag, ".b.beat"},  64'(if_b.beat_idx), 64'(beat));
    checkOutput({tag, ".b.flags"},
                64'({if_b.first_out, if_b.last_out, if_b.done_out, if_b.freeze_r, if_b.busy}),
                64'({f, l, dn, fr, bs}));
  endtask

  task automatic expectC(input string tag, input logic [15:0] d, input logic v, input int beat,
                         input logic f, input logic l, input logic dn, input logic fr, input logic bs);
    checkOutput({tag, ".c.data"},  64'(if_c.data_out), 64'(d));
    checkOutput({tag, ".c.valid"}, 64'(if_c.lane_valid), 64'(v));
    checkOutput({tag, ".c.beat"},  64'(if_c.beat_idx), 64'(beat));
    checkOutput({tag, ".c.flags"},
                64'({if_c.first_out, if_c.last_out, if_c.done_out, if_c.freeze_r, if_c.busy}),
                64'({f, l, dn, fr, bs}));
  endtask

  // Linear directed sequence; expected values are written out by hand from the block's behaviour.
  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    if_a.done_in  = 1'b0;
    if_a.stall_in = 1'b0;
    if_b.done_in  = 1'b0;
    if_b.stall_in = 1'b0;
    if_c.done_in  = 1'b0;
    if_c.stall_in = 1'b0;
    if_a.data_in  = {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    if_b.data_in  = {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    if_c.data_in  = 16'hABCD;

    // Reset state before any clock edge
    #2;
    expectA("reset", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);
    expectB("reset", 32'h0, 2'b00, 0, 0, 0, 0, 1, 0);
    expectC("reset", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);

    // Release reset and request a start on the very first edge afterwards
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0);

    // A: plain five-beat sequence
    for (int k = 0; k < 5; k++) begin
      expectA($sformatf("seq1.b%0d", k), 16'(k + 1), 1'b1, k, k == 0, k == 4, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
    end
    expectA("seq1.done", 16'h0, 1'b0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("seq1.idle", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);

    // A: three stalled cycles at beat 2
    applyStimulus(1, 0, 0, 0);
    expectA("stall.b0", 16'h0001, 1'b1, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    expectA("stall.b2", 16'h0003, 1'b1, 2, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    expectA("stall.h1", 16'h0003, 1'b1, 2, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    expectA("stall.h2", 16'h0003, 1'b1, 2, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    expectA("stall.h3", 16'h0003, 1'b1, 2, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("stall.b3", 16'h0004, 1'b1, 3, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("stall.b4", 16'h0005, 1'b1, 4, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("stall.done", 16'h0, 1'b0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 1, 0, 0);
    expectA("stall.idle", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    expectA("stall.idle2", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);

    // A: requests at beat 3 and in DONE merge into one back-to-back sequence
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    expectA("chain.b3", 16'h0004, 1'b1, 3, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    expectA("chain.b4", 16'h0005, 1'b1, 4, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("chain.done1", 16'h0, 1'b0, 0, 0, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 0);
    expectA("chain.s2b0", 16'h0001, 1'b1, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    expectA("chain.s2b4", 16'h0005, 1'b1, 4, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("chain.done2", 16'h0, 1'b0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    expectA("chain.idle", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    expectA("chain.noextra", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);

    // B: two lanes with a partial final beat
    applyStimulus(0, 0, 1, 0);
    expectB("lanes.b0", 32'h0002_0001, 2'b11, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectB("lanes.b1", 32'h0004_0003, 2'b11, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectB("lanes.b2", 32'h0000_0005, 2'b01, 2, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectB("lanes.done", 32'h0, 2'b00, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    expectB("lanes.idle", 32'h0, 2'b00, 0, 0, 0, 0, 1, 0);

    // B: asynchronous reset in the middle of beat 1
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    expectB("abort.b1", 32'h0004_0003, 2'b11, 1, 0, 0, 0, 0, 1);
    #3;
    rst = 1'b1;
    #1;
    expectB("abort.rst", 32'h0, 2'b00, 0, 0, 0, 0, 1, 0);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0);
    expectB("abort.nodone", 32'h0, 2'b00, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    expectB("abort.restart", 32'h0002_0001, 2'b11, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    expectB("abort.done", 32'h0, 2'b00, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);

    // C: single-word vector runs for exactly one beat
    applyStimulus(0, 0, 0, 1);
    expectC("single.b0", 16'hABCD, 1'b1, 0, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    expectC("single.done", 16'h0, 1'b0, 0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0);
    expectC("single.idle", 16'h0, 1'b0, 0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
